// File: rtl/fetch_prefetcher_pkg.sv
// Shared types and defaults for the fetch prefetcher: queue entry layout and reset constants.
package fetch_prefetcher_pkg;

    localparam int unsigned FETCH_WIDTH       = 32;
    localparam int unsigned DEFAULT_ROM_SIZE  = 128;
    localparam logic [FETCH_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instruction;
        logic                   fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetcher_queue.sv
// Circular prefetch FIFO of fetch entries; flush empties it and dominates push/pop.
module fetch_prefetcher_queue
    import fetch_prefetcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 entry,
    output logic                         full,
    output logic                         empty,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A push into a full queue is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_prefetcher.sv
// Fetch stage: PC sequencer with ROM read and fault detection feeding a prefetch queue toward decode.
module fetch_prefetcher
    import fetch_prefetcher_pkg::*;
#(
    parameter int unsigned      WIDTH    = FETCH_WIDTH,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      ROM_SIZE = DEFAULT_ROM_SIZE,
    parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rom [0:ROM_SIZE-1],
    input  logic                        redirect_valid,
    input  logic [WIDTH-1:0]            redirect_target,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_pc,
    output logic [WIDTH-1:0]            out_instruction,
    output logic                        out_fault,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int unsigned AW = $clog2(ROM_SIZE);

    logic [WIDTH-1:0] fetch_pc;
    logic             halted;
    logic [AW-1:0]    idx_c;
    logic             fault_c;
    logic [WIDTH-1:0] word_c;
    fetch_entry_t     entry_c;
    fetch_entry_t     head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    // Big-endian word read; faulting fetches carry a zero instruction.
    always_comb begin
        idx_c   = fetch_pc[AW-1:0];
        fault_c = (fetch_pc[1:0] != 2'b00) || (fetch_pc > WIDTH'(ROM_SIZE - 4));
        word_c  = '0;
        if (!fault_c) begin
            word_c = {rom[idx_c], rom[idx_c + AW'(1)], rom[idx_c + AW'(2)], rom[idx_c + AW'(3)]};
        end
        entry_c = '{pc: fetch_pc, instruction: word_c, fault: fault_c};
    end

    // A redirect cycle never hands off an entry, so its pop is void.
    assign out_valid = !empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && !halted && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            halted   <= 1'b0;
        end else if (push) begin
            if (fault_c) begin
                halted <= 1'b1;
            end else begin
                fetch_pc <= fetch_pc + WIDTH'(4);
            end
        end
    end

    fetch_prefetcher_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .entry (entry_c),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (occupancy)
    );

    assign out_pc          = head.pc;
    assign out_instruction = head.instruction;
    assign out_fault       = head.fault;

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Bench for fetch_prefetcher: scenario tasks checked against a queue-based reference model.
module tb_fetch_prefetcher;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ROM_SIZE = 128;
    localparam int unsigned CW       = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rom [0:ROM_SIZE-1];
    logic              redirect_valid;
    logic [WIDTH-1:0]  redirect_target;
    logic              out_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_pc;
    logic [WIDTH-1:0]  out_instruction;
    logic              out_fault;
    logic [CW-1:0]     occupancy;

    always #5 clk = ~clk;

    fetch_prefetcher #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ROM_SIZE (ROM_SIZE),
        .RESET_PC (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom             (rom),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_fault       (out_fault),
        .occupancy       (occupancy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {pc, instruction, fault}, next fetch address, halt flag.
    logic [64:0]  mq [$];
    logic [31:0]  m_pc;
    bit           m_halted;
    logic         exp_valid;
    logic [CW-1:0] exp_occ;
    logic [64:0]  exp_head;
    bit           ok;

    function automatic logic [64:0] ref_entry(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a > ROM_SIZE - 4)
            return {a, 32'h0, 1'b1};
        return {a, rom[a], rom[a+1], rom[a+2], rom[a+3], 1'b0};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
    endtask

    // Apply inputs (called at a falling edge) and derive what decode should see this cycle.
    task automatic drive(input bit redir, input logic [31:0] tgt, input bit rdy);
        redirect_valid  = redir;
        redirect_target = tgt;
        out_ready       = rdy;
        #1;
        exp_occ   = CW'(mq.size());
        exp_valid = (mq.size() != 0) && !redir;
        exp_head  = (mq.size() != 0) ? mq[0] : 65'h0;
    endtask

    // Move the model across the rising edge, then return at the next falling edge.
    task automatic advance();
        bit pop_m, push_m;
        logic [64:0] e;
        pop_m  = exp_valid && out_ready;
        push_m = !redirect_valid && !m_halted && (mq.size() < DEPTH || pop_m);
        @(posedge clk);
        if (redirect_valid) begin
            mq.delete();
            m_pc     = redirect_target;
            m_halted = 1'b0;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                e = ref_entry(m_pc);
                mq.push_back(e);
                if (e[0]) m_halted = 1'b1;
                else      m_pc     = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, occupancy, out_pc, out_instruction, out_fault} !== {1'b0, CW'(0), 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset valid=%0b occ=%0d pc=%h instr=%h fault=%0b expected all zero",
                     out_valid, occupancy, out_pc, out_instruction, out_fault);
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, 1'b1);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stream c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, '0, c >= 10);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL backpressure c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            if (c == 9) begin
                checks++;
                if (occupancy !== CW'(DEPTH)) begin
                    errors++;
                    $display("FAIL backpressure_saturate got occ=%0d expected %0d", occupancy, DEPTH);
                end
            end
            advance();
        end
    endtask

    task automatic test_redirect_flush();
        for (int c = 0; c < 12; c++) begin
            drive(c == 5, 32'h40, c > 5);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL redirect_flush c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            if (c == 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
                    errors++;
                    $display("FAIL redirect_latency got v=%0b pc=%h expected v=1 pc=00000040", out_valid, out_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_fault_halt();
        for (int c = 0; c < 14; c++) begin
            drive(c == 0 || c == 8, (c == 0) ? 32'h42 : 32'h44, 1'b1);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL fault_halt c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            if (c == 2) begin
                checks++;
                if ({out_valid, out_pc, out_instruction, out_fault} !== {1'b1, 32'h42, 32'h0, 1'b1}) begin
                    errors++;
                    $display("FAIL misaligned_entry got v=%0b pc=%h instr=%h fault=%0b expected v=1 pc=00000042 instr=0 fault=1",
                             out_valid, out_pc, out_instruction, out_fault);
                end
            end
            if (c == 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL halted_quiet got v=%0b expected 0", out_valid);
                end
            end
            advance();
        end
    endtask

    task automatic test_rom_end();
        for (int c = 0; c < 12; c++) begin
            drive(c == 0, ROM_SIZE - 16, 1'b1);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rom_end c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            if (c == 6) begin
                checks++;
                if ({out_valid, out_pc, out_fault} !== {1'b1, 32'(ROM_SIZE), 1'b1}) begin
                    errors++;
                    $display("FAIL rom_end_fault got v=%0b pc=%h fault=%0b expected v=1 pc=%h fault=1",
                             out_valid, out_pc, out_fault, 32'(ROM_SIZE));
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit redir;
        logic [31:0] tgt;
        for (int c = 0; c < 400; c++) begin
            redir = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0, 1:    tgt = {$urandom_range(0, ROM_SIZE/4 - 1), 2'b00};
                2:       tgt = {$urandom_range(0, ROM_SIZE/4 - 1), 2'b00} | 32'($urandom_range(1, 3));
                default: tgt = $urandom;
            endcase
            drive(redir, tgt, $urandom_range(0, 3) != 0);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 32'h10, 1'b0);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL prefill c=%0d got v=%0b occ=%0d expected v=%0b occ=%0d",
                         c, out_valid, occupancy, exp_valid, exp_occ);
            end
            advance();
        end
        checks++;
        if (occupancy !== CW'(3)) begin
            errors++;
            $display("FAIL prefill_occ got occ=%0d expected 3", occupancy);
        end
        out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, occupancy} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL async_reset got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b1);
            ok = ({out_valid, occupancy} === {exp_valid, exp_occ}) &&
                 (exp_occ == 0 || {out_pc, out_instruction, out_fault} === exp_head);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL after_reset c=%0d got v=%0b occ=%0d head=%h_%h_%0b expected v=%0b occ=%0d head=%h",
                         c, out_valid, occupancy, out_pc, out_instruction, out_fault, exp_valid, exp_occ, exp_head);
            end
            if (c == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL restart_pc got v=%0b pc=%h expected v=1 pc=00000000", out_valid, out_pc);
                end
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < int'(ROM_SIZE); i++) rom[i] = 8'($urandom);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_fault_halt();
        test_rom_end();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
